// File: rtl/pt_tx_sched.sv
// pt_tx_sched: FIFO-buffered scheduler that owns the PT2262 encoder's reset and ad lines.
// The optional abort/flush input is enabled by defining PT_SCHED_ABORT_EN.
module pt_tx_sched #(
  parameter int REPEAT = 4,
  parameter int DEPTH  = 4,
  parameter int GAP    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [23:0]            in_data,
  output logic                   in_ready,
  input  logic                   enc_done,
  output logic                   enc_rst,
  output logic [23:0]            enc_ad,
  input  logic                   abort,
  output logic                   busy,
  output logic [3:0]             rep,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0]  LAST_REP = 4'(REPEAT - 1);
  localparam logic [11:0] GAP_LAST = 12'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_GAP} state_t;

  state_t        state;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [11:0]   gap_cnt;
  logic          flush, push, pop, last_rep, pending;

`ifdef PT_SCHED_ABORT_EN
  assign flush = abort;
`else
  logic unused_abort;
  assign flush        = 1'b0;
  assign unused_abort = abort;
`endif

  assign in_ready = (count != LW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign last_rep = (rep == LAST_REP);
  assign pop      = (state == S_RUN) && enc_done && last_rep && !flush;
  assign pending  = (rep != '0) || (count != '0);
  assign busy     = (state != S_IDLE);
  assign level    = count;

  // In RUN the encoder's own done gates its reset, blocking its auto-restart.
  always_comb begin
    enc_rst = 1'b1;
    case (state)
      S_ARM:   enc_rst = 1'b0;
      S_RUN:   enc_rst = enc_done;
      default: enc_rst = 1'b1;
    endcase
    if (flush) enc_rst = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rep     <= '0;
      gap_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      enc_ad  <= '0;
      ovf     <= 1'b0;
    end else begin
      if (in_valid && !in_ready) ovf <= 1'b1;
      if (flush) begin
        state   <= S_IDLE;
        rep     <= '0;
        gap_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + LW'(push) - LW'(pop);
        case (state)
          S_IDLE: begin
            if (count != '0) begin
              state  <= S_ARM;
              enc_ad <= mem[rd_ptr];
            end
          end
          S_ARM: state <= S_RUN;
          S_RUN: begin
            if (enc_done) begin
              gap_cnt <= '0;
              if (!last_rep) begin
                rep <= rep + 4'(1);
                if (GAP == 0) begin
                  state  <= S_ARM;
                  enc_ad <= mem[rd_ptr];
                end else begin
                  state <= S_GAP;
                end
              end else begin
                rep <= '0;
                // Level after the pop excludes a same-cycle push; that word is picked up from IDLE.
                if (GAP != 0) begin
                  state <= S_GAP;
                end else if (count > LW'(1)) begin
                  state  <= S_ARM;
                  enc_ad <= mem[rd_ptr + AW'(1)];
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              if (pending) begin
                state  <= S_ARM;
                enc_ad <= mem[rd_ptr];
              end else begin
                state <= S_IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + 12'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pt_tx_sched.sv
// Bench for pt_tx_sched: two instances (REPEAT=4/GAP=0 and REPEAT=2/GAP=100) against a
// 512-cycle encoder model and a word/frame scoreboard. Honours PT_SCHED_ABORT_EN.
`timescale 1ns/1ps
module tb_pt_tx_sched;
  localparam int D = 4;
`ifdef PT_SCHED_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        abort = 1'b0;
  logic        in_ready [2];
  logic        enc_rst [2];
  logic        enc_done [2];
  logic        busy [2];
  logic        ovf [2];
  logic [23:0] enc_ad [2];
  logic [3:0]  rep [2];
  logic [2:0]  level [2];
  int          enc_cnt [2] = '{0, 0};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // scoreboard / reference state
  int          lvl_m [2] = '{0, 0};
  bit          ovf_m [2] = '{0, 0};
  bit          cur_last [2] = '{0, 0};
  logic [23:0] cur_w [2];
  logic [23:0] ew [2][64];
  int          er [2][64];
  int          eh [2] = '{0, 0};
  int          et [2] = '{0, 0};
  int          starts [2][32];
  int          ns [2] = '{0, 0};

  always #5 clk = ~clk;

  pt_tx_sched #(.REPEAT(4), .DEPTH(D), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .enc_done(enc_done[0]), .enc_rst(enc_rst[0]), .enc_ad(enc_ad[0]), .abort(abort),
    .busy(busy[0]), .rep(rep[0]), .level(level[0]), .ovf(ovf[0]));

  pt_tx_sched #(.REPEAT(2), .DEPTH(D), .GAP(100)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .enc_done(enc_done[1]), .enc_rst(enc_rst[1]), .enc_ad(enc_ad[1]), .abort(abort),
    .busy(busy[1]), .rep(rep[1]), .level(level[1]), .ovf(ovf[1]));

  // Encoder model: done while held in reset, then 511 busy cycles and a done cycle;
  // if reset is still low on the done cycle it reloads by itself.
  for (genvar g = 0; g < 2; g++) begin : g_enc
    assign enc_done[g] = (enc_cnt[g] == 0) || (enc_cnt[g] == 512);
    always @(posedge clk) begin
      if (enc_rst[g])               enc_cnt[g] <= 0;
      else if (enc_cnt[g] == 512)   enc_cnt[g] <= 1;
      else                          enc_cnt[g] <= enc_cnt[g] + 1;
    end
  end

  function automatic int rep_n(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Cycle monitor: compares occupancy/flags, scores every frame start, then advances the model.
  initial begin
    bit flush_m, push_m, pop_m;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        chk("level", k, level[k], lvl_m[k]);
        chk("in_ready", k, in_ready[k], lvl_m[k] < D);
        chk("ovf", k, ovf[k], ovf_m[k]);
        flush_m = rst || (ABORT_EN && abort);
        if (enc_cnt[k] == 512) begin
          chk("restart_guard", k, enc_rst[k], 1);
          chk("ad_hold", k, enc_ad[k], cur_w[k]);
        end
        if (!rst && !enc_rst[k] && enc_cnt[k] == 0) begin
          chk("frame_expected", k, et[k] != eh[k], 1);
          if (et[k] != eh[k]) begin
            chk("frame_ad", k, enc_ad[k], ew[k][eh[k] % 64]);
            chk("frame_rep", k, rep[k], er[k][eh[k] % 64]);
            cur_last[k] = (er[k][eh[k] % 64] == rep_n(k) - 1);
            cur_w[k] = ew[k][eh[k] % 64];
            eh[k]++;
            starts[k][ns[k] % 32] = cyc;
            ns[k]++;
          end
        end
        pop_m  = !flush_m && enc_cnt[k] == 512 && cur_last[k];
        push_m = !flush_m && in_valid && lvl_m[k] < D;
        if (rst) ovf_m[k] = 1'b0;
        else if (in_valid && lvl_m[k] >= D) ovf_m[k] = 1'b1;
        if (flush_m) begin
          lvl_m[k] = 0;
          eh[k] = et[k];
          cur_last[k] = 1'b0;
        end else begin
          if (push_m) begin
            for (int r = 0; r < rep_n(k); r++) begin
              ew[k][et[k] % 64] = in_data;
              er[k][et[k] % 64] = r;
              et[k]++;
            end
          end
          lvl_m[k] = lvl_m[k] + int'(push_m) - int'(pop_m);
          if (pop_m) cur_last[k] = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input int limit, output int nd0, output int nd1);
    int n;
    n = 1;
    nd0 = busy[0] ? 0 : 1;
    nd1 = busy[1] ? 0 : 1;
    while ((busy[0] || busy[1]) && n < limit) begin
      @(negedge clk);
      n++;
      if (!busy[0] && nd0 == 0) nd0 = n;
      if (!busy[1] && nd1 == 0) nd1 = n;
    end
    chk("idle_timeout", 0, busy[0] | busy[1], 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_enc_rst"}, k, enc_rst[k], 1);
      chk({tag, "_enc_ad"}, k, enc_ad[k], 0);
      chk({tag, "_in_ready"}, k, in_ready[k], 1);
      chk({tag, "_busy"}, k, busy[k], 0);
      chk({tag, "_rep"}, k, rep[k], 0);
      chk({tag, "_level"}, k, level[k], 0);
      chk({tag, "_ovf"}, k, ovf[k], 0);
    end
  endtask

  initial begin
    int nd0, nd1, n, lows;
    logic [23:0] w1, w2;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_vals("reset");

    // single word, four back-to-back frames on dut0
    ns[0] = 0; ns[1] = 0;
    @(negedge clk); in_valid = 1'b1; in_data = 24'hA5F00F;
    @(negedge clk); in_valid = 1'b0;
    #1;
    chk("push_level", 0, level[0], 1);
    chk("push_busy", 0, busy[0], 0);
    chk("push_enc_rst", 0, enc_rst[0], 1);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arm_busy", k, busy[k], 1);
      chk("arm_enc_rst", k, enc_rst[k], 0);
      chk("arm_enc_ad", k, enc_ad[k], 24'hA5F00F);
      chk("arm_rep", k, rep[k], 0);
    end
    wait_idle(3000, nd0, nd1);
    chk("single_total", 0, nd0, 2053);
    chk("single_total", 1, nd1, 1227);
    chk("single_frames", 0, ns[0], 4);
    chk("single_frames", 1, ns[1], 2);
    for (int i = 0; i + 1 < ns[0]; i++) chk("single_slot", 0, starts[0][i+1] - starts[0][i], 513);
    for (int k = 0; k < 2; k++) begin
      chk("single_end_level", k, level[k], 0);
      chk("single_end_enc_rst", k, enc_rst[k], 1);
      chk("single_exp_empty", k, et[k] - eh[k], 0);
    end

    // two words back-to-back: order and gap spacing
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    ns[0] = 0; ns[1] = 0;
    @(negedge clk); in_valid = 1'b1; in_data = w1;
    @(negedge clk); in_data = w2;
    @(negedge clk); in_valid = 1'b0;
    wait_idle(6000, nd0, nd1);
    chk("pair_total", 0, nd0, 4105);
    chk("pair_total", 1, nd1, 2453);
    chk("pair_frames", 0, ns[0], 8);
    chk("pair_frames", 1, ns[1], 4);
    for (int i = 0; i + 1 < ns[0]; i++) chk("pair_slot", 0, starts[0][i+1] - starts[0][i], 513);
    for (int i = 0; i + 1 < ns[1]; i++) chk("pair_slot", 1, starts[1][i+1] - starts[1][i], 613);
    for (int k = 0; k < 2; k++) chk("pair_exp_empty", k, et[k] - eh[k], 0);

    // overflow: five pushes into a 4-deep FIFO while the encoder is busy
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 24'($urandom);
    end
    @(negedge clk); in_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ovf_level", k, level[k], 4);
      chk("ovf_in_ready", k, in_ready[k], 0);
      chk("ovf_flag", k, ovf[k], 1);
    end
    wait_idle(12000, nd0, nd1);
    for (int k = 0; k < 2; k++) chk("ovf_exp_empty", k, et[k] - eh[k], 0);

    // rst mid-frame with three words queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 24'($urandom);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk_reset_vals("midrst");
    lows = 0;
    repeat (600) begin
      @(negedge clk);
      if (!enc_rst[0] || !enc_rst[1]) lows++;
    end
    chk("midrst_quiet", 0, lows, 0);

    // abort during cycle 200 of the second repeat, with a push in the same cycle
    w1 = 24'($urandom);
    @(negedge clk); in_valid = 1'b1; in_data = w1;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (!(rep[0] == 4'd1 && enc_rst[0] == 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rep1_reached", 0, n < 2000, 1);
    repeat (200) @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_data = 24'($urandom);
    #1;
    for (int k = 0; k < 2; k++) chk("abort_enc_rst", k, enc_rst[k], ABORT_EN);
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_level", k, level[k], ABORT_EN ? 0 : 2);
      chk("abort_busy", k, busy[k], ABORT_EN ? 0 : 1);
      chk("abort_rep", k, rep[k], ABORT_EN ? 0 : 1);
      chk("abort_ovf", k, ovf[k], 0);
    end
    w2 = 24'($urandom);
    @(negedge clk); in_valid = 1'b1; in_data = w2;
    @(negedge clk); in_valid = 1'b0;
    wait_idle(20000, nd0, nd1);
    for (int k = 0; k < 2; k++) begin
      chk("post_abort_exp_empty", k, et[k] - eh[k], 0);
      chk("post_abort_enc_rst", k, enc_rst[k], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
